// File: rtl/clock_sequencer_if.sv
// clock_sequencer_if: control inputs and phase/status outputs of the clock sequencer
interface clock_sequencer_if;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        ctrl_phase;
  logic        write_phase;
  logic        write_fall;
  logic        cpu_reset;
  logic        enabled;
  logic        running;
  logic        halted;
  logic [15:0] cycle_count;
  modport master (
    output run, step, halt_req,
    input  ctrl_phase, write_phase, write_fall, cpu_reset, enabled, running, halted, cycle_count
  );
  modport slave (
    input  run, step, halt_req,
    output ctrl_phase, write_phase, write_fall, cpu_reset, enabled, running, halted, cycle_count
  );
endinterface

// File: rtl/clock_sequencer.sv
// clock_sequencer: four-phase machine-cycle sequencer with reset hold, single step and halt
module clock_sequencer #(
  parameter int PHASE_LEN  = 2,
  parameter int RESET_HOLD = 4
) (
  input logic              clk,
  input logic              reset,
  clock_sequencer_if.slave bus
);
  typedef enum logic [2:0] {HOLD, STOPPED, C_HI, C_LO, W_HI, W_LO, HALTED} state_t;
  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d, ph_q, ph_d;
  logic        step_pending_q, step_pending_d, halt_q, halt_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic        busy, first, phase_end;
  always_comb begin
    busy = state_q inside {C_HI, C_LO, W_HI, W_LO};
    first = busy && ph_q == 4'd0;
    phase_end = ph_q == 4'(PHASE_LEN - 1);
    state_d = state_q;
    hold_d = hold_q;
    ph_d = busy ? (phase_end ? 4'd0 : ph_q + 4'd1) : 4'd0;
    step_pending_d = step_pending_q;
    halt_d = halt_q | (busy & bus.halt_req);
    cycle_count_d = cycle_count_q + 16'(state_q == W_LO && first);
    case (state_q)
      HOLD: begin
        hold_d = hold_q + 4'd1;
        if (hold_q == 4'(RESET_HOLD - 1)) state_d = STOPPED;
      end
      STOPPED: begin
        step_pending_d = step_pending_q | bus.step;
        if (bus.run | bus.step | step_pending_q) state_d = C_HI;
      end
      C_HI: if (phase_end) state_d = C_LO;
      C_LO: if (phase_end) state_d = W_HI;
      W_HI: if (phase_end) state_d = W_LO;
      W_LO: if (phase_end) begin
        if (halt_d) begin
          state_d = HALTED;
          halt_d = 1'b0;
        end else if (bus.run) begin
          state_d = C_HI;
        end else begin
          state_d = STOPPED;
          step_pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HOLD;
      hold_q <= '0;
      ph_q <= '0;
      step_pending_q <= 1'b0;
      halt_q <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      ph_q <= ph_d;
      step_pending_q <= step_pending_d;
      halt_q <= halt_d;
      cycle_count_q <= cycle_count_d;
    end
  end
  assign bus.ctrl_phase  = state_q == C_HI && first;
  assign bus.write_phase = state_q == W_HI && first;
  assign bus.write_fall  = state_q == W_LO && first;
  assign bus.cpu_reset   = state_q == HOLD;
  assign bus.enabled     = state_q != HOLD;
  assign bus.running     = busy;
  assign bus.halted      = state_q == HALTED;
  assign bus.cycle_count = cycle_count_q;
endmodule
